// File: rtl/modchip_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | modchip_pkg : shared types and constants for the modchip key paths       |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package modchip_pkg;

   localparam int FRAME_BITS = 9;
   localparam int BIT_IDX_W  = $clog2(FRAME_BITS);

   localparam logic [7:0] LED_GREEN   = 8'h0F;
   localparam logic [7:0] LED_RED     = 8'hF0;
   localparam logic [7:0] LED_OFF     = 8'h00;
   localparam logic [7:0] CORRECT_KEY = 8'h00;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      SHIFT    = 3'd2,
      WAIT_ACK = 3'd3,
      DONE     = 3'd4,
      ERROR    = 3'd5
   } state_t;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/modchip_sync2.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | modchip_sync2 : two-flop synchroniser for asynchronous level inputs      |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module modchip_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/modchip_key_writer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | modchip_key_writer : serial key-byte transmitter with parity and retry   |
// | Optional LED status register: MODCHIP_WRITER_LED_EN         Rev 1.0      |
// +-------------------------------------------------------------------------+
module modchip_key_writer #(
   parameter int CLK_DIV     = 50,
   parameter int ACK_TIMEOUT = 1023,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] key_in,
   output logic       uprocessor_dout,
   output logic       uprocessor_sclk,
   input  logic       uprocessor_ack,
   input  logic       uprocessor_nack,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [7:0] led_out
);
   import modchip_pkg::*;

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);

   localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]     DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(ACK_TIMEOUT);
   localparam logic [RTY_W-1:0]     RTY_MAX  = RTY_W'(MAX_RETRY);
   localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(FRAME_BITS - 1);

   state_t                state_q, state_d;
   logic [7:0]            key_q, key_d;
   logic                  parity_q, parity_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic [RTY_W-1:0]      retry_q, retry_d;
   logic                  error_q, error_d;
   logic                  dout_q, dout_d;
   logic                  sclk_q, sclk_d;
   logic                  ack_s, nack_s;
   logic                  accept;

   modchip_sync2 u_sync_ack  (.clk(clk), .rst(rst), .d(uprocessor_ack),  .q(ack_s));
   modchip_sync2 u_sync_nack (.clk(clk), .rst(rst), .d(uprocessor_nack), .q(nack_s));

   assign accept = (state_q == IDLE) && start;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         key_q     <= '0;
         parity_q  <= 1'b0;
         frame_q   <= '0;
         bit_idx_q <= '0;
         div_cnt_q <= '0;
         timer_q   <= '0;
         retry_q   <= '0;
         error_q   <= 1'b0;
         dout_q    <= 1'b0;
         sclk_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         parity_q  <= parity_d;
         frame_q   <= frame_d;
         bit_idx_q <= bit_idx_d;
         div_cnt_q <= div_cnt_d;
         timer_q   <= timer_d;
         retry_q   <= retry_d;
         error_q   <= error_d;
         dout_q    <= dout_d;
         sclk_q    <= sclk_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      parity_d  = parity_q;
      frame_d   = frame_q;
      bit_idx_d = bit_idx_q;
      div_cnt_d = div_cnt_q;
      timer_d   = timer_q;
      retry_d   = retry_q;
      error_d   = error_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = LOAD;
               key_d    = key_in;
               parity_d = even_parity(key_in);
               retry_d  = '0;
               error_d  = 1'b0;
            end
         end
         LOAD: begin
            frame_d   = {parity_q, key_q};
            bit_idx_d = '0;
            div_cnt_d = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (bit_idx_q == BIT_LAST) begin
                  state_d = WAIT_ACK;
                  timer_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         WAIT_ACK: begin
            // A simultaneous ack and nack is resolved as a nack.
            if (ack_s && !nack_s) begin
               state_d = DONE;
            end else if (nack_s || (timer_q == TMR_LAST)) begin
               if (retry_q < RTY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = LOAD;
               end else begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Line outputs are registered, so they trail the shift counters by a cycle.
   always_comb begin
      busy   = (state_q == LOAD) || (state_q == SHIFT) || (state_q == WAIT_ACK);
      done   = (state_q == DONE);
      error  = error_q;
      dout_d = (state_q == SHIFT) && frame_q[bit_idx_q];
      sclk_d = (state_q == SHIFT) && (div_cnt_q >= DIV_HALF);
   end

   assign uprocessor_dout = dout_q;
   assign uprocessor_sclk = sclk_q;

`ifdef MODCHIP_WRITER_LED_EN
   logic [7:0] led_q, led_d;

   always_comb begin
      led_d = led_q;
      if (accept || (state_d == ERROR)) begin
         led_d = LED_RED;
      end else if (state_d == DONE) begin
         led_d = LED_GREEN;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q <= LED_OFF;
      end else begin
         led_q <= led_d;
      end
   end

   assign led_out = led_q;
`else
   assign led_out = LED_OFF;
`endif

endmodule
`default_nettype wire

// File: tb/tb_modchip_key_writer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_modchip_key_writer : self-checking bench for modchip_key_writer       |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_modchip_key_writer;

   localparam int CLK_DIV     = 4;
   localparam int ACK_TIMEOUT = 20;
   localparam int MAX_RETRY   = 3;
   localparam int R_ACK       = 0;
   localparam int R_NACK      = 1;
   localparam int R_SILENT    = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] key_in = 8'h00;
   logic       ack = 1'b0;
   logic       nack = 1'b0;
   logic       dout, sclk, busy, done, error;
   logic [7:0] led_out;

   always #5 clk = ~clk;

   modchip_key_writer #(
      .CLK_DIV(CLK_DIV), .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in),
      .uprocessor_dout(dout), .uprocessor_sclk(sclk),
      .uprocessor_ack(ack), .uprocessor_nack(nack),
      .busy(busy), .done(done), .error(error), .led_out(led_out)
   );

   int total = 0;
   int bad   = 0;

   // Bench-side receiver: samples data on each bit-clock rise, 9 bits per frame.
   logic [8:0] rx_q [$];
   int         bit_n = 0;
   logic [8:0] sh = '0;
   int         done_cnt = 0;

   always @(posedge sclk or negedge rst) begin
      if (!rst) begin
         bit_n <= 0;
      end else begin
         sh[bit_n] <= dout;
         if (bit_n == 8) begin
            rx_q.push_back({dout, sh[7:0]});
            bit_n <= 0;
         end else begin
            bit_n <= bit_n + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst && done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef logic [3:0][1:0] resp_t;

   function automatic resp_t mk(input int r0, input int r1, input int r2, input int r3);
      resp_t r;
      r[0] = 2'(r0); r[1] = 2'(r1); r[2] = 2'(r2); r[3] = 2'(r3);
      return r;
   endfunction

   // Outcome rule: one frame per response, stop at first ack, at most MAX_RETRY+1 frames.
   function automatic void model(input resp_t resp, output int frames, output bit ok);
      frames = 0;
      ok     = 1'b0;
      for (int i = 0; i <= MAX_RETRY; i++) begin
         frames++;
         if (resp[i] == 2'(R_ACK)) begin
            ok = 1'b1;
            break;
         end
      end
   endfunction

   function automatic logic [7:0] led_busy();
`ifdef MODCHIP_WRITER_LED_EN
      return 8'hF0;
`else
      return 8'h00;
`endif
   endfunction

   function automatic logic [7:0] led_final(input bit ok);
`ifdef MODCHIP_WRITER_LED_EN
      return ok ? 8'h0F : 8'hF0;
`else
      return ok ? 8'h00 : 8'h00;
`endif
   endfunction

   task automatic run_txn(input logic [7:0] key, input resp_t resp, input bit collide,
                          input int exp_frames, input bit exp_done, input string tag);
      int base, d0, nfr, waited, r, got;
      bit timed_out;
      base = rx_q.size();
      d0   = done_cnt;
      nfr  = 0;
      timed_out = 1'b0;
      @(negedge clk);
      key_in = key;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      key_in = ~key;
      check({tag, "_busy"}, busy, 1);
      check({tag, "_err_clr"}, error, 0);
      check({tag, "_led_busy"}, led_out, led_busy());
      while (busy === 1'b1 && !timed_out) begin
         waited = 0;
         while (rx_q.size() == base + nfr && busy === 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
            if (collide && nfr == 0 && waited == 15) begin
               key_in = 8'h11;
               start  = 1'b1;
            end else begin
               start = 1'b0;
            end
         end
         start = 1'b0;
         if (rx_q.size() == base + nfr && busy === 1'b1) begin
            timed_out = 1'b1;
         end else if (rx_q.size() > base + nfr) begin
            r = (nfr < 4) ? int'(resp[nfr]) : R_SILENT;
            nfr++;
            repeat (10) @(negedge clk);
            if (r == R_ACK)  ack  = 1'b1;
            if (r == R_NACK) nack = 1'b1;
            repeat (3) @(negedge clk);
            ack  = 1'b0;
            nack = 1'b0;
         end
      end
      check({tag, "_no_hang"}, timed_out, 0);
      repeat (40) @(negedge clk);
      got = rx_q.size() - base;
      check({tag, "_frames"}, got, exp_frames);
      check({tag, "_done_pulses"}, done_cnt - d0, exp_done ? 1 : 0);
      check({tag, "_error"}, error, exp_done ? 0 : 1);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_led_end"}, led_out, led_final(exp_done));
      for (int i = base; i < rx_q.size(); i++) begin
         check({tag, "_data"}, rx_q[i][7:0], key);
         check({tag, "_parity"}, rx_q[i][8], ^key);
      end
   endtask

   typedef struct {
      logic [7:0] key;
      resp_t      resp;
      bit         collide;
      int         exp_frames;
      bit         exp_done;
      string      name;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int   k, w, base, frames;
      bit   ok;
      logic [7:0] rk;
      resp_t rr;

      vecs[0] = '{8'hA5, mk(R_ACK, R_ACK, R_ACK, R_ACK),          1'b0, 1, 1'b1, "basic"};
      vecs[1] = '{8'h01, mk(R_ACK, R_ACK, R_ACK, R_ACK),          1'b0, 1, 1'b1, "parity"};
      vecs[2] = '{8'h3C, mk(R_NACK, R_ACK, R_ACK, R_ACK),         1'b0, 2, 1'b1, "nack_retry"};
      vecs[3] = '{8'h5A, mk(R_SILENT, R_SILENT, R_SILENT, R_SILENT), 1'b0, 4, 1'b0, "timeout"};
      vecs[4] = '{8'hE7, mk(R_ACK, R_ACK, R_ACK, R_ACK),          1'b0, 1, 1'b1, "after_err"};
      vecs[5] = '{8'h22, mk(R_ACK, R_ACK, R_ACK, R_ACK),          1'b1, 1, 1'b1, "collide"};
      vecs[6] = '{8'hC3, mk(R_NACK, R_SILENT, R_NACK, R_ACK),     1'b0, 4, 1'b1, "last_chance"};
      vecs[7] = '{8'hFF, mk(R_NACK, R_NACK, R_NACK, R_NACK),      1'b0, 4, 1'b0, "nack_exhaust"};

      #22;
      check("rst_dout", dout, 0);
      check("rst_sclk", sclk, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_led", led_out, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i].key, vecs[i].resp, vecs[i].collide,
                 vecs[i].exp_frames, vecs[i].exp_done, vecs[i].name);
      end

      // First bit-clock rise relative to the accepting clock edge.
      @(negedge clk);
      key_in = 8'h96;
      start  = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         k++;
      end while (sclk !== 1'b1 && k < 30);
      check("sclk_latency", k - 1, 2 + CLK_DIV / 2);

      // Asynchronous reset while bit 4 is on the line.
      w = 0;
      while (bit_n != 5 && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("reach_bit4", bit_n, 5);
      #1;
      check("pre_rst_sclk", sclk, 1);
      base = rx_q.size();
      rst = 1'b0;
      #1;
      check("mid_rst_dout", dout, 0);
      check("mid_rst_sclk", sclk, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_error", error, 0);
      check("mid_rst_led", led_out, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (60) @(negedge clk);
      check("post_rst_idle", busy, 0);
      check("post_rst_no_frame", rx_q.size() - base, 0);
      run_txn(8'h96, mk(R_ACK, R_ACK, R_ACK, R_ACK), 1'b0, 1, 1'b1, "post_rst");

      // Start issued during the DONE cycle must be dropped.
      base = rx_q.size();
      @(negedge clk);
      key_in = 8'h6B;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (rx_q.size() == base && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("donecyc_frame", rx_q.size() - base, 1);
      repeat (10) @(negedge clk);
      ack = 1'b1;
      w = 0;
      while (done !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("donecyc_done_seen", done, 1);
      key_in = 8'h77;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ack   = 1'b0;
      check("donecyc_start_ignored", busy, 0);
      repeat (60) @(negedge clk);
      check("donecyc_no_extra", rx_q.size() - base, 1);

      for (int n = 0; n < 12; n++) begin
         rk = 8'($urandom);
         for (int j = 0; j < 4; j++) rr[j] = 2'($urandom_range(0, 2));
         model(rr, frames, ok);
         run_txn(rk, rr, 1'b0, frames, ok, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/modchip_key_writer.md
Name: modchip_key_writer

Overview:
- FPGA-side transmitter that sends one 8-bit key byte to the microprocessor over a 3-wire serial link (data, bit clock, ack/nack), for the microprocessor to commit to EEPROM.
- Counterpart of the microprocessor-to-FPGA key-read path. The byte written here is the byte later returned on uprocessor_din.
- Sits between the board switch/key-select logic and the microprocessor header. Handles framing, parity, ack timeout and bounded retry.

Parameters:
- CLK_DIV, 50, clk cycles per serial bit period (>=4, even)
- ACK_TIMEOUT, 1023, max clk cycles to wait for ack/nack after the parity bit
- MAX_RETRY, 3, retransmissions after a nack or timeout before declaring error

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to send key_in; ignored while busy
- key_in  in  8  key byte; sampled on the accepted start cycle
- uprocessor_dout  out  1  serial data, LSB first, then even parity bit
- uprocessor_sclk  out  1  bit clock to microprocessor; data stable while high
- uprocessor_ack  in  1  microprocessor accepted frame (level, synchronised internally)
- uprocessor_nack  in  1  microprocessor rejected frame (parity fail)
- busy  out  1  high from accepted start until DONE/ERROR
- done  out  1  one-cycle pulse on successful ack
- error  out  1  sticky until next accepted start
- led_out  out  8  status LEDs (see Optional Feature)

Behaviour:
- Reset values: uprocessor_dout=0, uprocessor_sclk=0, busy=0, done=0, error=0, led_out=8'h00. All counters cleared, state IDLE.
- ack/nack pass through 2-flop synchronisers. Decisions use the synchronised values (2-cycle latency).
- States and transitions:
  - IDLE: start=1 → LOAD. Latch key_in; parity = XOR of key bits; retry_cnt=0; error cleared; busy=1 next cycle.
  - LOAD: one cycle; build 9-bit frame {parity, key}; bit_idx=0 → SHIFT.
  - SHIFT: for each of 9 bits, dout holds frame[bit_idx] for CLK_DIV cycles. sclk=0 for the first CLK_DIV/2 cycles of the period, 1 for the rest. After bit 8 → WAIT_ACK. sclk=0, dout=0.
  - WAIT_ACK: timer counts from 0.
    - ack=1 → DONE.
    - nack=1, or timer reaches ACK_TIMEOUT → RETRY check.
    - ack and nack both high in the same cycle is treated as nack.
  - RETRY check: retry_cnt<MAX_RETRY → increment, → LOAD (same latched byte). Otherwise → ERROR.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
  - ERROR: error=1 (sticky), busy=0 → IDLE.
- Frame duration: 9*CLK_DIV cycles. Accepted start to first sclk rise: 2 + CLK_DIV/2 cycles.
- start while busy is ignored. A start arriving in the DONE/ERROR cycle is also ignored; it is accepted only in IDLE.
- Asynchronous reset mid-frame: outputs go to reset values immediately. No partial frame resumes.
- Counter widths: $clog2(CLK_DIV), $clog2(ACK_TIMEOUT+1), $clog2(MAX_RETRY+1); no wrap-around possible.

Optional Feature:
- Macro: MODCHIP_WRITER_LED_EN.
- Defined: led_out follows the board status convention.
  - 8'hF0 (red) while busy or after error.
  - 8'h0F (green) after done.
  - Holds until next accepted start or reset.
- Undefined: led_out tied to 8'h00 and the LED register is not built.

Decomposition:
- Shared package modchip_pkg:
  - state enum (IDLE, LOAD, SHIFT, WAIT_ACK, DONE, ERROR)
  - FRAME_BITS=9
  - LED_GREEN=8'h0F, LED_RED=8'hF0, LED_OFF=8'h00
  - CORRECT_KEY constant (8'h00), shared with the read path.
- One sub-module: modchip_sync2, a 2-flop synchroniser instantiated for ack and for nack.

Test Plan:
- Basic send: CLK_DIV=4, key_in=8'hA5, start, ack 10 cycles after parity bit.
  - dout sequence LSB first is 1,0,1,0,0,1,0,1, then parity 0.
  - done pulses once; busy falls; led_out=8'h0F.
- Parity: key_in=8'h01 → parity bit=1. Bench checks the parity bit and that the bench-side receiver reassembles 8'h01.
- Nack retry: key 8'h3C. Nack the first frame, ack the second.
  - Exactly 2 frames observed, done=1, error=0.
- Timeout exhaustion: never ack, MAX_RETRY=3, ACK_TIMEOUT=20.
  - 4 frames sent; error=1 sticky; led_out=8'hF0.
  - Next start clears error.
- Busy/start collision: pulse start with key 8'h11 mid-frame of key 8'h22.
  - Only 8'h22 is transmitted; no second frame follows.
- Reset mid-SHIFT: assert rst low at bit 4.
  - All outputs are 0 within the same cycle; state returns to IDLE.
  - Subsequent start sends a complete frame.
